// File: rtl/uart_rx_ctrl_if.sv
// rtl/uart_rx_ctrl_if.sv - port-mapped host bus between processor and uart_rx_ctrl
interface uart_rx_ctrl_if;
    logic [7:0] port_id;
    logic       read_strobe;
    logic       write_strobe;
    logic [7:0] out_port;
    logic [7:0] in_port;
    logic       interrupt;
    logic       interrupt_ack;

    modport master (
        output port_id, read_strobe, write_strobe, out_port, interrupt_ack,
        input  in_port, interrupt
    );

    modport slave (
        input  port_id, read_strobe, write_strobe, out_port, interrupt_ack,
        output in_port, interrupt
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// rtl/uart_rx_ctrl.sv - UART RX capture FSM, byte FIFO, engine config and host port
// Optional error-byte discard with counter: define UART_RX_ERR_DISCARD_EN.
module uart_rx_ctrl #(
    parameter int         DEPTH     = 8,
    parameter logic [7:0] PORT_DATA = 8'h00,
    parameter logic [7:0] PORT_STAT = 8'h01,
    parameter logic [7:0] PORT_CFG  = 8'h02
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       rx_rdy,
    input  logic [7:0] uart_data,
    input  logic       perr,
    input  logic       ferr,
    input  logic       ovf,
    output logic       rx_clr,
    output logic [3:0] baud,
    output logic       eight,
    output logic       pen,
    output logic       ohel,
    uart_rx_ctrl_if.slave host
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, CAPTURE, CLEAR} state_t;
    state_t state, state_nxt;

    logic [10:0]   mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          drop;
    logic          capture, full, empty, err_any, discard;
    logic          push_req, push_ok, pop, flush, cfg_wr, stat_rd, drop_set;
    logic [10:0]   head;
    logic [7:0]    rd_mux;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= CLEAR;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (rx_rdy) state_nxt = CAPTURE;
            CAPTURE: state_nxt = CLEAR;
            CLEAR:   if (!rx_rdy) state_nxt = IDLE;
            default: state_nxt = CLEAR;
        endcase
    end

    // rx_clr is held low while RESET is asserted even though the state is CLEAR
    always_comb begin
        rx_clr  = (state == CLEAR) && !RESET;
        capture = (state == CAPTURE);
    end

    assign err_any = ovf | ferr | perr;
`ifdef UART_RX_ERR_DISCARD_EN
    localparam logic [7:0] PORT_CNT = PORT_CFG + 8'd1;
    logic [7:0] err_cnt;
    logic       cnt_rd;
    assign discard = capture & err_any;
    assign cnt_rd  = host.read_strobe && (host.port_id == PORT_CNT);

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)                            err_cnt <= 8'h00;
        else if (cnt_rd)                      err_cnt <= discard ? 8'h01 : 8'h00;
        else if (discard && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'h01;
    end
`else
    assign discard = 1'b0;
    logic unused_err;
    assign unused_err = err_any;
`endif

    assign full     = (count == FULL_CNT);
    assign empty    = (count == '0);
    assign head     = mem[rd_ptr];
    assign cfg_wr   = host.write_strobe && (host.port_id == PORT_CFG);
    assign flush    = cfg_wr & host.out_port[7];
    assign stat_rd  = host.read_strobe && (host.port_id == PORT_STAT);
    assign push_req = capture & ~discard;
    // fullness is judged before any same-cycle pop; flush beats push
    assign drop_set = push_req & full;
    assign push_ok  = push_req & ~full & ~flush;
    assign pop      = host.read_strobe && (host.port_id == PORT_DATA) && !empty && !flush;

    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= {ovf, ferr, perr, uart_data};
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + AW'(1);
            if (pop)     rd_ptr <= rd_ptr + AW'(1);
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            drop           <= 1'b0;
            host.interrupt <= 1'b0;
            baud           <= 4'b1011;
            eight          <= 1'b1;
            pen            <= 1'b0;
            ohel           <= 1'b0;
        end else begin
            if (drop_set)     drop <= 1'b1;
            else if (stat_rd) drop <= 1'b0;
            if (push_ok)                 host.interrupt <= 1'b1;
            else if (host.interrupt_ack) host.interrupt <= 1'b0;
            if (cfg_wr) begin
                baud  <= host.out_port[3:0];
                eight <= host.out_port[4];
                pen   <= host.out_port[5];
                ohel  <= host.out_port[6];
            end
        end
    end

    always_comb begin
        rd_mux = 8'h00;
        if (host.port_id == PORT_DATA)
            rd_mux = empty ? 8'h00 : head[7:0];
        else if (host.port_id == PORT_STAT)
            rd_mux = {2'b00, (empty ? 3'b000 : head[10:8]), drop, full, ~empty};
`ifdef UART_RX_ERR_DISCARD_EN
        else if (host.port_id == PORT_CNT)
            rd_mux = err_cnt;
`endif
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) host.in_port <= 8'h00;
        else       host.in_port <= rd_mux;
    end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb/tb_uart_rx_ctrl.sv - directed vector bench for uart_rx_ctrl (default build)
module tb_uart_rx_ctrl;
    localparam logic [7:0] PD = 8'h00, PS = 8'h01, PC = 8'h02, PX = 8'h03;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       rx_rdy;
    logic [7:0] uart_data;
    logic       perr, ferr, ovf;
    logic       rx_clr;
    logic [3:0] baud;
    logic       eight, pen, ohel;
    int         total = 0;
    int         bad = 0;

    uart_rx_ctrl_if bus ();

    uart_rx_ctrl dut (
        .CLK(CLK), .RESET(RESET), .rx_rdy(rx_rdy), .uart_data(uart_data),
        .perr(perr), .ferr(ferr), .ovf(ovf), .rx_clr(rx_clr), .baud(baud),
        .eight(eight), .pen(pen), .ohel(ohel), .host(bus.slave)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic       rdy;
        logic [7:0] d;
        logic [2:0] err;
        logic [7:0] pid;
        logic       rd;
        logic       ack;
        logic [7:0] e_in;
        logic       e_clr;
        logic       e_int;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic rdy, logic [7:0] d, logic [2:0] err, logic [7:0] pid,
                                logic rd, logic ack, logic [7:0] e_in, logic e_clr, logic e_int);
        vec_t v;
        v.rdy = rdy; v.d = d; v.err = err; v.pid = pid; v.rd = rd; v.ack = ack;
        v.e_in = e_in; v.e_clr = e_clr; v.e_int = e_int;
        return v;
    endfunction

    task automatic chk(string nm, logic [7:0] act, logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(logic rdy, logic [7:0] d, logic [2:0] err, logic [7:0] pid,
                         logic rd, logic wr, logic [7:0] wd, logic ack);
        rx_rdy = rdy; uart_data = d; {ovf, ferr, perr} = err;
        bus.port_id = pid; bus.read_strobe = rd; bus.write_strobe = wr;
        bus.out_port = wd; bus.interrupt_ack = ack;
    endtask

    task automatic recv(logic [7:0] d);
        drive(1'b1, d, 3'b000, PS, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        tick();
        drive(1'b0, 8'h00, 3'b000, PS, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
    endtask

    initial begin
        RESET = 1'b1;
        drive(1'b1, 8'h00, 3'b000, PS, 1'b0, 1'b0, 8'h00, 1'b0);
        #1;
        chk("rst_in_port", bus.in_port, 8'h00);
        chk("rst_rx_clr", {7'd0, rx_clr}, 8'h00);
        chk("rst_int", {7'd0, bus.interrupt}, 8'h00);
        chk("rst_cfg", {ohel, pen, eight, baud}, 7'b0011011);
        tick();
        tick();
        RESET = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stale_rx_clr", {7'd0, rx_clr}, 8'h01);
        end
        rx_rdy = 1'b0;
        tick();
        chk("stale_rx_clr_off", {7'd0, rx_clr}, 8'h00);
        chk("stale_stat", bus.in_port, 8'h00);
        chk("stale_int", {7'd0, bus.interrupt}, 8'h00);

        tv.push_back(mk(1, 8'h5A, 3'b000, PS, 0, 0, 8'h00, 0, 0));
        tv.push_back(mk(1, 8'h5A, 3'b000, PS, 0, 0, 8'h00, 1, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PS, 0, 0, 8'h01, 0, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PD, 1, 0, 8'h5A, 0, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PS, 0, 0, 8'h00, 0, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PS, 0, 1, 8'h00, 0, 0));
        tv.push_back(mk(1, 8'hC3, 3'b011, PS, 0, 0, 8'h00, 0, 0));
        tv.push_back(mk(1, 8'hC3, 3'b011, PS, 0, 0, 8'h00, 1, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PS, 0, 0, 8'h19, 0, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PX, 0, 0, 8'h00, 0, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PD, 0, 0, 8'hC3, 0, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, 8'h7F, 0, 0, 8'h00, 0, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PS, 1, 0, 8'h19, 0, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PD, 1, 1, 8'hC3, 0, 0));
        tv.push_back(mk(0, 8'h00, 3'b000, PS, 0, 0, 8'h00, 0, 0));
        tv.push_back(mk(1, 8'hA5, 3'b000, PS, 0, 0, 8'h00, 0, 0));
        tv.push_back(mk(1, 8'hA5, 3'b000, PS, 0, 1, 8'h00, 1, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PD, 1, 0, 8'hA5, 0, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PS, 0, 0, 8'h00, 0, 1));
        tv.push_back(mk(1, 8'h3C, 3'b100, PS, 0, 1, 8'h00, 0, 0));
        tv.push_back(mk(1, 8'h3C, 3'b100, PS, 0, 0, 8'h00, 1, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PS, 0, 0, 8'h21, 0, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PD, 1, 0, 8'h3C, 0, 1));
        tv.push_back(mk(0, 8'h00, 3'b000, PS, 0, 1, 8'h00, 0, 0));

        foreach (tv[i]) begin
            drive(tv[i].rdy, tv[i].d, tv[i].err, tv[i].pid, tv[i].rd, 1'b0, 8'h00, tv[i].ack);
            tick();
            chk($sformatf("vec%0d_in_port", i), bus.in_port, tv[i].e_in);
            chk($sformatf("vec%0d_rx_clr", i), {7'd0, rx_clr}, {7'd0, tv[i].e_clr});
            chk($sformatf("vec%0d_int", i), {7'd0, bus.interrupt}, {7'd0, tv[i].e_int});
        end

        // nine bytes into eight entries
        for (int i = 1; i <= 9; i++) recv(8'(i));
        tick();
        chk("ovfl_stat", bus.in_port, 8'h07);
        for (int i = 1; i <= 8; i++) begin
            drive(1'b0, 8'h00, 3'b000, PD, 1'b1, 1'b0, 8'h00, 1'b0);
            tick();
            chk("ovfl_data", bus.in_port, 8'(i));
        end
        drive(1'b0, 8'h00, 3'b000, PS, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("ovfl_stat_empty", bus.in_port, 8'h04);
        bus.read_strobe = 1'b1;
        tick();
        chk("ovfl_stat_rd", bus.in_port, 8'h04);
        bus.read_strobe = 1'b0;
        tick();
        chk("ovfl_drop_clr", bus.in_port, 8'h00);
        bus.interrupt_ack = 1'b1;
        tick();
        bus.interrupt_ack = 1'b0;
        chk("ovfl_ack", {7'd0, bus.interrupt}, 8'h00);

        // capture coinciding with a pop at 7 entries
        for (int i = 0; i < 7; i++) recv(8'h10 + 8'(i));
        drive(1'b1, 8'h17, 3'b000, PS, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h17, 3'b000, PD, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        chk("pp7_pop", bus.in_port, 8'h10);
        drive(1'b0, 8'h00, 3'b000, PS, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("pp7_stat", bus.in_port, 8'h01);
        for (int i = 1; i <= 7; i++) begin
            drive(1'b0, 8'h00, 3'b000, PD, 1'b1, 1'b0, 8'h00, 1'b0);
            tick();
            chk("pp7_data", bus.in_port, 8'h10 + 8'(i));
        end
        drive(1'b0, 8'h00, 3'b000, PS, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("pp7_empty", bus.in_port, 8'h00);

        // same at 8 entries: judged full before the pop, byte dropped
        for (int i = 0; i < 8; i++) recv(8'h20 + 8'(i));
        drive(1'b1, 8'h28, 3'b000, PS, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h28, 3'b000, PD, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        chk("pp8_pop", bus.in_port, 8'h20);
        drive(1'b0, 8'h00, 3'b000, PS, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("pp8_stat", bus.in_port, 8'h05);
        for (int i = 1; i <= 7; i++) begin
            drive(1'b0, 8'h00, 3'b000, PD, 1'b1, 1'b0, 8'h00, 1'b0);
            tick();
            chk("pp8_data", bus.in_port, 8'h20 + 8'(i));
        end
        drive(1'b0, 8'h00, 3'b000, PS, 1'b1, 1'b0, 8'h00, 1'b0);
        tick();
        chk("pp8_stat_rd", bus.in_port, 8'h04);
        drive(1'b0, 8'h00, 3'b000, PS, 1'b0, 1'b0, 8'h00, 1'b1);
        tick();
        chk("pp8_empty", bus.in_port, 8'h00);
        chk("pp8_ack", {7'd0, bus.interrupt}, 8'h00);

        // config write with flush
        for (int i = 0; i < 3; i++) recv(8'h31 + 8'(i));
        tick();
        chk("cfg_pre_stat", bus.in_port, 8'h01);
        drive(1'b0, 8'h00, 3'b000, PC, 1'b0, 1'b1, 8'hB5, 1'b1);
        tick();
        chk("cfg_b5", {ohel, pen, eight, baud}, 7'b0110101);
        drive(1'b0, 8'h00, 3'b000, PS, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("cfg_flush_stat", bus.in_port, 8'h00);

        // flush colliding with a capture: the capture is lost
        drive(1'b1, 8'h99, 3'b000, PS, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        drive(1'b1, 8'h99, 3'b000, PC, 1'b0, 1'b1, 8'h8B, 1'b0);
        tick();
        chk("flush_push_clr", {7'd0, rx_clr}, 8'h01);
        drive(1'b0, 8'h00, 3'b000, PS, 1'b0, 1'b0, 8'h00, 1'b0);
        tick();
        chk("flush_push_stat", bus.in_port, 8'h00);
        chk("flush_push_int", {7'd0, bus.interrupt}, 8'h00);
        chk("cfg_8b", {ohel, pen, eight, baud}, 7'b0001011);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_ctrl.md
Name: uart_rx_ctrl

Overview:
Sequencing and host-interface controller for the UART receive engine. It detects RX_RDY, captures the received byte and its error flags into a small FIFO, and pulses the engine's status-clear input. It also owns the engine configuration register (BAUD/EIGHT/PEN/OHEL) and gives the PicoBlaze-style processor a port-mapped read/write interface with an interrupt.

Parameters:
DEPTH, 8, FIFO entries; power of two, 2..16.
PORT_DATA, 8'h00, port_id that returns the FIFO head data byte and pops the FIFO.
PORT_STAT, 8'h01, port_id for the status byte.
PORT_CFG, 8'h02, port_id for the configuration register (write).

Ports:
CLK  in  1  clock
RESET  in  1  reset; asynchronous, active-high
rx_rdy  in  1  engine RX_STATUS
uart_data  in  8  engine UART_DATA
perr, ferr, ovf  in  1 each  engine error flags
rx_clr  out  1  to engine reads_0
baud  out  4  engine BAUD
eight, pen, ohel  out  1 each  engine framing config
port_id  in  8  host port address
read_strobe, write_strobe  in  1 each  host strobes
out_port  in  8  host write data
in_port  out  8  host read data, registered
interrupt  out  1  receive interrupt
interrupt_ack  in  1  clears interrupt

Behaviour:
- Reset values:
  - Outputs: rx_clr=0, baud=4'b1011, eight=1, pen=0, ohel=0, in_port=0, interrupt=0.
  - Internal: FIFO empty, drop=0.
  - FSM enters CLEAR, because the engine resets with RX_RDY=1 and that stale flag must be cleared without pushing anything.
- Capture FSM (registered), states IDLE, CAPTURE, CLEAR:
  - IDLE: rx_rdy=1 at an edge -> CAPTURE.
  - CAPTURE, one cycle: push {ovf,ferr,perr,uart_data} (11 bits) if the FIFO is not full; otherwise set sticky drop and discard. -> CLEAR.
  - CLEAR: rx_clr=1, decoded from state. Hold while rx_rdy=1; go to IDLE on the first edge with rx_rdy=0.
  - Latency: rx_rdy high sampled at edge k; FIFO written at edge k+1; rx_clr high from k+1 until rx_rdy is seen low.
  - RESET mid-capture: the partial entry is lost and the FSM returns to CLEAR.
- FIFO:
  - Pointers are log2(DEPTH) bits and wrap modulo DEPTH. The count register is log2(DEPTH)+1 bits.
  - Full and empty are decoded from count.
  - Push and pop in the same cycle: both occur and count is unchanged.
  - Push on full is judged on pre-pop state: the byte is dropped even if a pop happens in the same cycle.
  - Pop on empty is ignored.
- Host read: in_port is updated every CLK from port_id.
  - PORT_DATA returns the head data byte, or 8'h00 if empty.
  - PORT_STAT returns {2'b00, head_ovf, head_ferr, head_perr, drop, full, ~empty}. Head flags read 0 when empty.
  - Unmapped port_id returns 8'h00.
  - read_strobe & port_id==PORT_DATA pops at that edge.
  - read_strobe & port_id==PORT_STAT clears drop at that edge. If a new drop happens in the same cycle, drop stays 1.
- Host write: write_strobe & port_id==PORT_CFG loads baud=out_port[3:0], eight=[4], pen=[5], ohel=[6].
  - out_port[7]=1 flushes the FIFO at that edge; flush takes priority over a push in the same cycle.
  - Config is not stored with bit 7; the new config is visible on the outputs on the next cycle.
- Interrupt:
  - Set on every successful push; cleared by interrupt_ack.
  - Push and ack in the same cycle: interrupt stays 1.

Optional Feature:
UART_RX_ERR_DISCARD_EN
- Defined:
  - Bytes with any error flag set are not pushed and do not raise interrupt.
  - An 8-bit saturating counter (max 8'hFF) counts them and is readable at PORT_CFG+1.
  - Reading that port clears the counter; a discard in the same cycle sets it to 1.
  - rx_clr sequencing is unchanged.
- Undefined: all bytes are pushed with their flags, and PORT_CFG+1 reads 8'h00.

Test Plan:
- Assert RESET with rx_rdy=1; release, hold rx_rdy=1 for 3 cycles, then 0 -> rx_clr high 3 cycles, FIFO empty, STAT=8'h00, baud=4'hB, eight=1, interrupt=0.
- rx_rdy rises with uart_data=8'h5A and no errors -> rx_clr one edge after capture, interrupt=1, STAT=8'h01; read PORT_DATA -> 8'h5A, then STAT=8'h00; interrupt_ack -> interrupt=0.
- Receive 9 bytes 8'h01..8'h09 with no reads -> STAT=8'h07; first 8 reads return 8'h01..8'h08; one STAT read clears drop.
- Byte 8'hC3 with ferr=1, perr=1 -> STAT=8'h19; with UART_RX_ERR_DISCARD_EN, FIFO stays empty and PORT_CFG+1 reads 8'h01, then 8'h00.
- FIFO holds 7 entries; capture coincides with a PORT_DATA read -> count stays 7, order preserved. Repeat at 8 entries -> byte dropped, drop=1.
- Write PORT_CFG with 8'hB5 while FIFO holds 3 entries -> FIFO empty, baud=4'h5, eight=1, pen=1, ohel=0.
